// File: rtl/cmsdk_mcu_rst_seq.sv
// Reset sequencer and APB clock-enable generator: merges reset requests, holds/staggers HRESETn/PRESETn.
// Optional sticky reset-cause register is enabled by defining CMSDK_MCU_RSTCAUSE_EN.
module cmsdk_mcu_rst_seq #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int PCLK_DIV    = 2
) (
    input  logic               FCLK,
    input  logic               PORESET,
    input  logic [NUM_REQ-1:0] RESET_REQ,
    input  logic               RSTCAUSE_CLR,
    output logic               HRESETn,
    output logic               PRESETn,
    output logic               PCLKEN,
    output logic               RST_BUSY,
    output logic [NUM_REQ:0]   RSTCAUSE
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PCLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_STAGGER,
        ST_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             req_any;

    assign req_any = |RESET_REQ;

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            HRESETn  <= 1'b0;
            PRESETn  <= 1'b0;
            RST_BUSY <= 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (req_any) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        HRESETn <= 1'b1;
                        if (STAGGER == 0) begin
                            PRESETn  <= 1'b1;
                            RST_BUSY <= 1'b0;
                            state    <= ST_RUN;
                        end else begin
                            state <= ST_STAGGER;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STAGGER: begin
                    if (req_any) begin
                        cnt     <= '0;
                        HRESETn <= 1'b0;
                        PRESETn <= 1'b0;
                        state   <= ST_ASSERT;
                    end else if (cnt == STG_LAST) begin
                        cnt      <= '0;
                        PRESETn  <= 1'b1;
                        RST_BUSY <= 1'b0;
                        state    <= ST_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (req_any) begin
                        cnt      <= '0;
                        HRESETn  <= 1'b0;
                        PRESETn  <= 1'b0;
                        RST_BUSY <= 1'b1;
                        state    <= ST_ASSERT;
                    end
                end
                default: begin
                    cnt      <= '0;
                    HRESETn  <= 1'b0;
                    PRESETn  <= 1'b0;
                    RST_BUSY <= 1'b1;
                    state    <= ST_ASSERT;
                end
            endcase
        end
    end

    // Divider runs from power-on only so the APB cadence is stable across warm resets.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            div_cnt <= '0;
            PCLKEN  <= (PCLK_DIV == 1);
        end else begin
            PCLKEN  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

`ifdef CMSDK_MCU_RSTCAUSE_EN
    localparam logic [NUM_REQ:0] CAUSE_POR = {{NUM_REQ{1'b0}}, 1'b1};

    logic [NUM_REQ:0] cause;

    // A request on the same edge as a clear keeps its bit set.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            cause <= CAUSE_POR;
        end else begin
            cause <= (RSTCAUSE_CLR ? '0 : cause) | {RESET_REQ, 1'b0};
        end
    end

    assign RSTCAUSE = cause;
`else
    logic unused_clr;

    assign unused_clr = RSTCAUSE_CLR;
    assign RSTCAUSE   = '0;
`endif

endmodule

// File: tb/tb_cmsdk_mcu_rst_seq.sv
// Directed self-checking bench for cmsdk_mcu_rst_seq (NUM_REQ=4, HOLD=16, STAGGER=4, PCLK_DIV=4),
// plus a PCLK_DIV=1 instance for the constant-enable case.
module tb_cmsdk_mcu_rst_seq;

    logic       FCLK         = 1'b0;
    logic       PORESET      = 1'b1;
    logic [3:0] RESET_REQ    = 4'b0000;
    logic       RSTCAUSE_CLR = 1'b0;
    logic       HRESETn, PRESETn, PCLKEN, RST_BUSY;
    logic [4:0] RSTCAUSE;
    logic       h1, p1, pclken1, busy1;
    logic [4:0] cause1;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

`ifdef CMSDK_MCU_RSTCAUSE_EN
    localparam bit CAUSE_EN = 1'b1;
`else
    localparam bit CAUSE_EN = 1'b0;
`endif

    cmsdk_mcu_rst_seq #(
        .NUM_REQ(4), .HOLD_CYCLES(16), .STAGGER(4), .PCLK_DIV(4)
    ) dut (
        .FCLK(FCLK), .PORESET(PORESET), .RESET_REQ(RESET_REQ), .RSTCAUSE_CLR(RSTCAUSE_CLR),
        .HRESETn(HRESETn), .PRESETn(PRESETn), .PCLKEN(PCLKEN), .RST_BUSY(RST_BUSY),
        .RSTCAUSE(RSTCAUSE)
    );

    cmsdk_mcu_rst_seq #(
        .NUM_REQ(4), .HOLD_CYCLES(16), .STAGGER(4), .PCLK_DIV(1)
    ) dut_div1 (
        .FCLK(FCLK), .PORESET(PORESET), .RESET_REQ(RESET_REQ), .RSTCAUSE_CLR(RSTCAUSE_CLR),
        .HRESETn(h1), .PRESETn(p1), .PCLKEN(pclken1), .RST_BUSY(busy1),
        .RSTCAUSE(cause1)
    );

    always #5 FCLK = ~FCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    // Outputs after this task reflect the state registered at edge edge_n.
    task automatic step();
        @(posedge FCLK);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int k);
        while (edge_n < k) step();
    endtask

    task automatic do_poreset();
        #2 PORESET = 1'b1;
        @(negedge FCLK);
        PORESET = 1'b0;
        edge_n  = 0;
    endtask

    task automatic test_reset();
        #12;
        checks += 6;
        if (HRESETn !== 1'b0) begin failures++; $display("FAIL reset_hresetn: got %b expected 0", HRESETn); end
        if (PRESETn !== 1'b0) begin failures++; $display("FAIL reset_presetn: got %b expected 0", PRESETn); end
        if (RST_BUSY !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", RST_BUSY); end
        if (PCLKEN !== 1'b0) begin failures++; $display("FAIL reset_pclken: got %b expected 0", PCLKEN); end
        if (pclken1 !== 1'b1) begin failures++; $display("FAIL reset_pclken_div1: got %b expected 1", pclken1); end
        if (RSTCAUSE !== (CAUSE_EN ? 5'b00001 : 5'b00000)) begin
            failures++; $display("FAIL reset_cause: got %b expected %b", RSTCAUSE, CAUSE_EN ? 5'b00001 : 5'b00000);
        end
        @(negedge FCLK);
        PORESET = 1'b0;
        edge_n  = 0;
    endtask

    // Assumes PORESET was just released (edge_n == 0).
    task automatic test_power_on();
        logic exp_h, exp_p;
        for (int e = 1; e <= 22; e++) begin
            step();
            exp_h = (e >= 16);
            exp_p = (e >= 20);
            checks += 3;
            if (HRESETn !== exp_h) begin failures++; $display("FAIL por_hresetn@%0d: got %b expected %b", e, HRESETn, exp_h); end
            if (PRESETn !== exp_p) begin failures++; $display("FAIL por_presetn@%0d: got %b expected %b", e, PRESETn, exp_p); end
            if (RST_BUSY !== !exp_p) begin failures++; $display("FAIL por_busy@%0d: got %b expected %b", e, RST_BUSY, !exp_p); end
        end
        checks++;
        if (RSTCAUSE !== (CAUSE_EN ? 5'b00001 : 5'b00000)) begin
            failures++; $display("FAIL por_cause: got %b expected %b", RSTCAUSE, CAUSE_EN ? 5'b00001 : 5'b00000);
        end
    endtask

    task automatic test_single_req();
        logic exp_h, exp_p;
        run_to(99);
        RESET_REQ = 4'b0010;
        step();
        RESET_REQ = 4'b0000;
        checks += 3;
        if (HRESETn !== 1'b0) begin failures++; $display("FAIL single_hresetn@100: got %b expected 0", HRESETn); end
        if (PRESETn !== 1'b0) begin failures++; $display("FAIL single_presetn@100: got %b expected 0", PRESETn); end
        if (RST_BUSY !== 1'b1) begin failures++; $display("FAIL single_busy@100: got %b expected 1", RST_BUSY); end
        for (int e = 101; e <= 122; e++) begin
            step();
            exp_h = (e >= 116);
            exp_p = (e >= 120);
            checks += 2;
            if (HRESETn !== exp_h) begin failures++; $display("FAIL single_hresetn@%0d: got %b expected %b", e, HRESETn, exp_h); end
            if (PRESETn !== exp_p) begin failures++; $display("FAIL single_presetn@%0d: got %b expected %b", e, PRESETn, exp_p); end
        end
        checks++;
        if (RSTCAUSE !== (CAUSE_EN ? 5'b00101 : 5'b00000)) begin
            failures++; $display("FAIL single_cause: got %b expected %b", RSTCAUSE, CAUSE_EN ? 5'b00101 : 5'b00000);
        end
    endtask

    task automatic test_held_reentry();
        logic exp_h;
        do_poreset();
        run_to(199);
        RESET_REQ = 4'b0001;
        run_to(229);
        RESET_REQ = 4'b0000;
        checks += 2;
        if (HRESETn !== 1'b0) begin failures++; $display("FAIL held_hresetn@229: got %b expected 0", HRESETn); end
        if (RST_BUSY !== 1'b1) begin failures++; $display("FAIL held_busy@229: got %b expected 1", RST_BUSY); end
        for (int e = 230; e <= 246; e++) begin
            step();
            exp_h = (e >= 245);
            checks += 2;
            if (HRESETn !== exp_h) begin failures++; $display("FAIL held_hresetn@%0d: got %b expected %b", e, HRESETn, exp_h); end
            if (PRESETn !== 1'b0) begin failures++; $display("FAIL held_presetn@%0d: got %b expected 0", e, PRESETn); end
        end
        RESET_REQ = 4'b0100;
        step();
        RESET_REQ = 4'b0000;
        checks += 4;
        if (HRESETn !== 1'b0) begin failures++; $display("FAIL reentry_hresetn@247: got %b expected 0", HRESETn); end
        if (PRESETn !== 1'b0) begin failures++; $display("FAIL reentry_presetn@247: got %b expected 0", PRESETn); end
        if (RST_BUSY !== 1'b1) begin failures++; $display("FAIL reentry_busy@247: got %b expected 1", RST_BUSY); end
        if (RSTCAUSE !== (CAUSE_EN ? 5'b01011 : 5'b00000)) begin
            failures++; $display("FAIL reentry_cause: got %b expected %b", RSTCAUSE, CAUSE_EN ? 5'b01011 : 5'b00000);
        end
        run_to(262);
        checks++;
        if (HRESETn !== 1'b0) begin failures++; $display("FAIL reentry_hresetn@262: got %b expected 0", HRESETn); end
        step();
        checks++;
        if (HRESETn !== 1'b1) begin failures++; $display("FAIL reentry_hresetn@263: got %b expected 1", HRESETn); end
    endtask

    task automatic test_clear_collision();
        RSTCAUSE_CLR = 1'b1;
        RESET_REQ    = 4'b1000;
        step();
        RSTCAUSE_CLR = 1'b0;
        RESET_REQ    = 4'b0000;
        checks++;
        if (RSTCAUSE !== (CAUSE_EN ? 5'b10000 : 5'b00000)) begin
            failures++; $display("FAIL collision_cause: got %b expected %b", RSTCAUSE, CAUSE_EN ? 5'b10000 : 5'b00000);
        end
        RSTCAUSE_CLR = 1'b1;
        step();
        RSTCAUSE_CLR = 1'b0;
        checks++;
        if (RSTCAUSE !== 5'b00000) begin failures++; $display("FAIL clear_cause: got %b expected 00000", RSTCAUSE); end
    endtask

    task automatic test_pclken();
        logic exp_en;
        do_poreset();
        for (int e = 1; e <= 40; e++) begin
            RESET_REQ = (e == 10 || e == 11) ? 4'b0010 : 4'b0000;
            step();
            exp_en = (e % 4 == 0);
            checks += 2;
            if (PCLKEN !== exp_en) begin failures++; $display("FAIL pclken@%0d: got %b expected %b", e, PCLKEN, exp_en); end
            if (pclken1 !== 1'b1) begin failures++; $display("FAIL pclken_div1@%0d: got %b expected 1", e, pclken1); end
        end
        RESET_REQ = 4'b0000;
    endtask

    task automatic test_poreset_mid();
        do_poreset();
        run_to(4);
        RSTCAUSE_CLR = 1'b1;
        step();
        RSTCAUSE_CLR = 1'b0;
        run_to(18);
        checks += 2;
        if (HRESETn !== 1'b1) begin failures++; $display("FAIL mid_pre_hresetn@18: got %b expected 1", HRESETn); end
        if (PRESETn !== 1'b0) begin failures++; $display("FAIL mid_pre_presetn@18: got %b expected 0", PRESETn); end
        #2 PORESET = 1'b1;
        #1;
        checks += 4;
        if (HRESETn !== 1'b0) begin failures++; $display("FAIL mid_hresetn: got %b expected 0", HRESETn); end
        if (PRESETn !== 1'b0) begin failures++; $display("FAIL mid_presetn: got %b expected 0", PRESETn); end
        if (RST_BUSY !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", RST_BUSY); end
        if (RSTCAUSE !== (CAUSE_EN ? 5'b00001 : 5'b00000)) begin
            failures++; $display("FAIL mid_cause: got %b expected %b", RSTCAUSE, CAUSE_EN ? 5'b00001 : 5'b00000);
        end
        @(negedge FCLK);
        PORESET = 1'b0;
        edge_n  = 0;
        test_power_on();
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_single_req();
        test_held_reentry();
        test_clear_collision();
        test_pclken();
        test_poreset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
